// File: rtl/sram_ctrl_pkg.sv
// Shared types and helpers for the OpenRAM data-SRAM request controller.
package sram_ctrl_pkg;

  localparam int unsigned SRAM_WORD_AW = 8;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    CAP,
    RMW_RD,
    RMW_WR,
    WR,
    RESP
  } state_t;

  // Spare bit value that makes the 33-bit stored word XOR to zero.
  function automatic logic even_parity(input logic [31:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/sram_byte_merge.sv
// Combinational 4-byte strobe merge: strobed bytes come from new_word, the rest from old_word.
module sram_byte_merge (
  input  logic [31:0] old_word,
  input  logic [31:0] new_word,
  input  logic [3:0]  strb,
  output logic [31:0] merged
);

  always_comb begin
    merged = old_word;
    for (int unsigned i = 0; i < 4; i++) begin
      if (strb[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
  end

endmodule

// File: rtl/sram_rmw_ctrl.sv
// Single-outstanding load/store controller for the 256-word OpenRAM data SRAM.
// Partial stores run as read-modify-write; define SRAM_PARITY_EN to store/check parity in spare bit 32.
module sram_rmw_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned SRAM_ADDR_WIDTH = SRAM_WORD_AW,
  parameter int unsigned SRAM_DATA_WIDTH = 33
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_we,
  input  logic [31:0]                req_addr,
  input  logic [3:0]                 req_wstrb,
  input  logic [31:0]                req_wdata,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [31:0]                rsp_rdata,
  output logic                       rsp_err,
  output logic                       sram_csb,
  output logic                       sram_web,
  output logic                       sram_spare_wen,
  output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
  output logic [SRAM_DATA_WIDTH-1:0] sram_din,
  input  logic [SRAM_DATA_WIDTH-1:0] sram_dout
);

`ifdef SRAM_PARITY_EN
  localparam logic PARITY_EN = 1'b1;
`else
  localparam logic PARITY_EN = 1'b0;
`endif

  state_t                     state_q, state_d;
  logic [31:0]                wdata_q, wdata_d;
  logic [3:0]                 wstrb_q, wstrb_d;
  logic                       req_ready_d;
  logic                       rsp_valid_d, rsp_err_d;
  logic [31:0]                rsp_rdata_d;
  logic                       csb_d, web_d, spare_d;
  logic [SRAM_ADDR_WIDTH-1:0] addr_d;
  logic [SRAM_DATA_WIDTH-1:0] din_d;
  logic [31:0]                merged;
  logic                       accept, out_of_range, rd_perr;

  assign accept       = req_valid & req_ready;
  assign out_of_range = |req_addr[31:SRAM_ADDR_WIDTH+2];
  assign rd_perr      = PARITY_EN & (^sram_dout);

  // dout is consumed straight off the macro at the RMW_WR edge, so no capture flop is needed.
  sram_byte_merge u_merge (
    .old_word (sram_dout[31:0]),
    .new_word (wdata_q),
    .strb     (wstrb_q),
    .merged   (merged)
  );

  function automatic logic [SRAM_DATA_WIDTH-1:0] write_word(input logic [31:0] d);
    logic [SRAM_DATA_WIDTH-1:0] w;
    w       = '0;
    w[31:0] = d;
    w[32]   = PARITY_EN & even_parity(d);
    return w;
  endfunction

  always_comb begin
    state_d     = state_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rsp_valid_d = rsp_valid;
    rsp_rdata_d = rsp_rdata;
    rsp_err_d   = rsp_err;
    csb_d       = 1'b1;
    web_d       = 1'b1;
    spare_d     = 1'b0;
    addr_d      = sram_addr;
    din_d       = sram_din;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          wdata_d = req_wdata;
          wstrb_d = req_wstrb;
          if (out_of_range) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b1;
          end else if (!req_we) begin
            state_d = RD;
            csb_d   = 1'b0;
            addr_d  = req_addr[SRAM_ADDR_WIDTH+1:2];
          end else if (req_wstrb == 4'b1111) begin
            state_d = WR;
            csb_d   = 1'b0;
            web_d   = 1'b0;
            spare_d = PARITY_EN;
            addr_d  = req_addr[SRAM_ADDR_WIDTH+1:2];
            din_d   = write_word(req_wdata);
          end else if (req_wstrb == 4'b0000) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b0;
          end else begin
            state_d = RMW_RD;
            csb_d   = 1'b0;
            addr_d  = req_addr[SRAM_ADDR_WIDTH+1:2];
          end
        end
      end
      RD:  state_d = CAP;
      CAP: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_err_d   = rd_perr;
        rsp_rdata_d = rd_perr ? '0 : sram_dout[31:0];
      end
      RMW_RD: state_d = RMW_WR;
      RMW_WR: begin
        if (rd_perr) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
        end else begin
          state_d = WR;
          csb_d   = 1'b0;
          web_d   = 1'b0;
          spare_d = PARITY_EN;
          din_d   = write_word(merged);
        end
      end
      WR: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    req_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      wdata_q        <= '0;
      wstrb_q        <= '0;
      req_ready      <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_rdata      <= '0;
      rsp_err        <= 1'b0;
      sram_csb       <= 1'b1;
      sram_web       <= 1'b1;
      sram_spare_wen <= 1'b0;
      sram_addr      <= '0;
      sram_din       <= '0;
    end else begin
      state_q        <= state_d;
      wdata_q        <= wdata_d;
      wstrb_q        <= wstrb_d;
      req_ready      <= req_ready_d;
      rsp_valid      <= rsp_valid_d;
      rsp_rdata      <= rsp_rdata_d;
      rsp_err        <= rsp_err_d;
      sram_csb       <= csb_d;
      sram_web       <= web_d;
      sram_spare_wen <= spare_d;
      sram_addr      <= addr_d;
      sram_din       <= din_d;
    end
  end

endmodule
